// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants, entry layout and PC helper for the fetch queue.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] IALIGN_MASK      = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Sequential successor of a word-aligned PC; wraps FFFF_FFFC to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return (pc + 32'd4) & IALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - DEPTH x 64 {pc, inst} FIFO with push, pop, clear and head outputs.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [63:0]   push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [63:0]   head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push  = push & ~clear;
    do_pop   = pop & ~clear & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // The issue throttle in the parent must keep a push from ever landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push & ~clear) |-> (({1'b0, count_q} - {{CW{1'b0}}, do_pop}) < (CW + 1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue: owns the fetch PC, issues sequential
// reads to a 1-cycle synchronous RAM and buffers {pc, inst} for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [63:0]   head_data;
  logic          push;
  logic          pop;
  fq_entry_t     push_entry;
  fq_entry_t     head_entry;

  // Outstanding words (queued plus the one on the RAM bus) bound how far ahead we fetch.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  always_comb begin
    imem_req  = ~rst & (redirect | (occupancy < (CW + 1)'(DEPTH)));
    imem_addr = (redirect & ~rst) ? (redirect_pc & IALIGN_MASK) : fetch_pc_q;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (imem_req) begin
      fetch_pc_d    = next_pc(imem_addr);
      inflight_d    = 1'b1;
      inflight_pc_d = imem_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A redirect drops the response of the old stream and any pop offered alongside it.
  always_comb begin
    push            = inflight_q & ~redirect;
    pop             = inst_valid & inst_ready & ~redirect;
    push_entry.pc   = inflight_pc_q;
    push_entry.inst = imem_rdata;
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head_data (head_data)
  );

  assign head_entry = fq_entry_t'(head_data);
  assign inst_valid = (count != '0);
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= ram_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare, then advance the model.
  task automatic cycle(input bit rs, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          ev;
    bit          er;
    logic [31:0] ea;
    logic [63:0] head;
    @(negedge clk);
    rst = rs;
    redirect = rd;
    redirect_pc = rpc;
    inst_ready = rdy;
    #1;
    if (rs) begin
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
      mq.delete();
      m_pc = RESET_PC;
      m_infl = 1'b0;
    end else begin
      ev = (mq.size() != 0);
      er = rd || ((mq.size() + int'(m_infl)) < DEPTH);
      ea = rd ? (rpc & 32'hFFFF_FFFC) : m_pc;
      check("valid", {31'b0, inst_valid}, {31'b0, ev});
      check("req", {31'b0, imem_req}, {31'b0, er});
      check("addr", imem_addr, ea);
      if (ev) begin
        head = mq[0];
        check("inst_pc", inst_pc, head[63:32]);
        check("inst", inst, head[31:0]);
      end
      if (rd) begin
        mq.delete();
      end else begin
        if (ev && rdy) void'(mq.pop_front());
        if (m_infl) mq.push_back({m_infl_pc, ram_word(m_infl_pc)});
      end
      m_infl = er;
      if (er) begin
        m_infl_pc = ea;
        m_pc = ea + 32'd4;
      end
    end
  endtask

  initial begin
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (i == 0) check("r0_req", {31'b0, imem_req}, 32'd1);
      if (i == 1) check("r1_valid", {31'b0, inst_valid}, 32'd0);
      if (i == 2) check("r2_pc", inst_pc, RESET_PC);
      if (i == 3) check("r3_pc", inst_pc, RESET_PC + 32'd4);
    end

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, inst_valid}, 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 6 && !(mq.size() == 3 && m_infl); i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("redir_v0", {31'b0, inst_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("redir_v1", {31'b0, inst_valid}, 32'd1);
    check("redir_pc", inst_pc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("rp_valid", {31'b0, inst_valid}, 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("rp_pc", inst_pc, 32'h0000_0200);

    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("wrap_pc1", inst_pc, 32'h0000_0000);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("wrap_pc2", inst_pc, 32'h0000_0004);

    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (i == 0) check("post_addr", imem_addr, RESET_PC);
      if (i == 2) check("post_pc", inst_pc, RESET_PC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
